// File: rtl/display_msg_buffer.sv
// rtl/display_msg_buffer.sv - timestamped display-record FIFO with 64-bit word serializer
//
// Checkers and assertion sites post display records: message ID, severity and up to
// MAX_ARGS argument words. Each accepted record is stamped with the free-running cycle
// counter, queued, and streamed to the host as:
//   word 0 : header {sev[63:62], nargs[61:60], 28'b0, id zero-extended to 32 bits}
//   word 1 : timestamp
//   word 2+: arg0 .. arg(nargs-1), with out_last on the final word
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   msg_valid/ready     producer handshake
//   msg_id/sev/nargs    record fields (nargs above MAX_ARGS is clamped)
//   msg_args            argument i in bits [i*ARG_W +: ARG_W]
//   out_valid/ready     host stream handshake
//   out_data/out_last   serialized word and end-of-message marker
//   cycle_count         free-running 64-bit cycle counter
//   error_seen          sticky, set once an ERROR/FATAL record is accepted
//   msg_count           accepted records, saturating
//   drop_count          discarded records, saturating (drop mode only, else 0)
//
// Build option: DISPBUF_DROP_EN - never stall producers; records offered while the
// FIFO is full are discarded and counted in drop_count.

module display_msg_buffer #(
  parameter int DEPTH    = 16,
  parameter int MAX_ARGS = 2,
  parameter int ARG_W    = 64,
  parameter int ID_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [ID_W-1:0]           msg_id,
  input  logic [1:0]                msg_sev,
  input  logic [1:0]                msg_nargs,
  input  logic [MAX_ARGS*ARG_W-1:0] msg_args,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ARG_W-1:0]          out_data,
  output logic                      out_last,
  output logic [63:0]               cycle_count,
  output logic                      error_seen,
  output logic [15:0]               msg_count,
  output logic [15:0]               drop_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ARGS_W = MAX_ARGS * ARG_W;
  localparam logic [1:0] MAX_NARGS = 2'(MAX_ARGS);

  // Record storage, one slot per message.
  logic [1:0]        mem_sev   [DEPTH];
  logic [ID_W-1:0]   mem_id    [DEPTH];
  logic [1:0]        mem_nargs [DEPTH];
  logic [ARGS_W-1:0] mem_args  [DEPTH];
  logic [63:0]       mem_ts    [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;
  logic [1:0]       nargs_clamped;

  // Serializer: widx is the index of the word currently held in the output register.
  logic [2:0]       widx;
  logic             load;
  logic [PTR_W-1:0] sel_ptr;
  logic [2:0]       sel_idx;
  logic [1:0]       sel_sev;
  logic [ID_W-1:0]  sel_id;
  logic [1:0]       sel_nargs;
  logic [ARGS_W-1:0] sel_args;
  logic [63:0]      sel_ts;
  logic [ARG_W-1:0] next_word;
  logic             next_last;

  assign full          = (count == CNT_W'(DEPTH));
  assign nargs_clamped = (msg_nargs > MAX_NARGS) ? MAX_NARGS : msg_nargs;

`ifdef DISPBUF_DROP_EN
  logic drop;

  assign msg_ready = 1'b1;
  assign push      = msg_valid && !full;
  assign drop      = msg_valid && full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  // No bypass when full: a pop in the same cycle only frees the slot for the next one.
  assign msg_ready  = !full;
  assign push       = msg_valid && !full;
  assign drop_count = '0;
`endif

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sev[wr_ptr]   <= msg_sev;
      mem_id[wr_ptr]    <= msg_id;
      mem_nargs[wr_ptr] <= nargs_clamped;
      mem_args[wr_ptr]  <= msg_args;
      mem_ts[wr_ptr]    <= cycle_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Decide what the output register loads next. On the final word of the head record
  // the next record (if already queued) is loaded straight away so back-to-back
  // records stream without a gap.
  always_comb begin
    pop     = 1'b0;
    load    = 1'b0;
    sel_ptr = rd_ptr;
    sel_idx = 3'd0;
    if (!out_valid) begin
      load = (count != '0);
    end else if (out_ready) begin
      if (out_last) begin
        pop     = 1'b1;
        sel_ptr = rd_ptr + PTR_W'(1);
        load    = (count > CNT_W'(1));
      end else begin
        load    = 1'b1;
        sel_idx = widx + 3'd1;
      end
    end
  end

  assign sel_sev   = mem_sev[sel_ptr];
  assign sel_id    = mem_id[sel_ptr];
  assign sel_nargs = mem_nargs[sel_ptr];
  assign sel_args  = mem_args[sel_ptr];
  assign sel_ts    = mem_ts[sel_ptr];

  function automatic logic [ARG_W-1:0] word_sel(
    input logic [1:0]        sev,
    input logic [ID_W-1:0]   id,
    input logic [1:0]        na,
    input logic [ARGS_W-1:0] args,
    input logic [63:0]       ts,
    input logic [2:0]        idx
  );
    logic [63:0]      hdr;
    logic [ARG_W-1:0] w;
    logic [2:0]       ai;
    hdr = {sev, na, 28'd0, 32'(id)};
    w   = '0;
    ai  = idx - 3'd2;
    case (idx)
      3'd0:    w = ARG_W'(hdr);
      3'd1:    w = ARG_W'(ts);
      default: begin
        for (int k = 0; k < MAX_ARGS; k++) begin
          if (ai == 3'(k)) begin
            w = args[k*ARG_W +: ARG_W];
          end
        end
      end
    endcase
    return w;
  endfunction

  assign next_word = word_sel(sel_sev, sel_id, sel_nargs, sel_args, sel_ts, sel_idx);
  assign next_last = (sel_idx == ({1'b0, sel_nargs} + 3'd1));

  // Registered output stage; holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      widx      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= next_word;
      out_last  <= next_last;
      widx      <= sel_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      error_seen  <= 1'b0;
      msg_count   <= '0;
    end else begin
      cycle_count <= cycle_count + 64'd1;
      if (push && msg_sev[1]) begin
        error_seen <= 1'b1;
      end
      if (push && msg_count != 16'hFFFF) begin
        msg_count <= msg_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_display_msg_buffer.sv
// tb/tb_display_msg_buffer.sv - directed self-checking bench for display_msg_buffer

module tb_display_msg_buffer;

  localparam int DEPTH    = 16;
  localparam int MAX_ARGS = 2;
  localparam int ARG_W    = 64;
  localparam int ID_W     = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      msg_valid;
  logic                      msg_ready;
  logic [ID_W-1:0]           msg_id;
  logic [1:0]                msg_sev;
  logic [1:0]                msg_nargs;
  logic [MAX_ARGS*ARG_W-1:0] msg_args;
  logic                      out_valid;
  logic                      out_ready;
  logic [ARG_W-1:0]          out_data;
  logic                      out_last;
  logic [63:0]               cycle_count;
  logic                      error_seen;
  logic [15:0]               msg_count;
  logic [15:0]               drop_count;

  always #5 clk = ~clk;

  display_msg_buffer #(
    .DEPTH(DEPTH), .MAX_ARGS(MAX_ARGS), .ARG_W(ARG_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_id(msg_id), .msg_sev(msg_sev), .msg_nargs(msg_nargs), .msg_args(msg_args),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cycle_count(cycle_count), .error_seen(error_seen),
    .msg_count(msg_count), .drop_count(drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Bench-side cycle reference for timestamps.
  logic [63:0] tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 64'd1;
  end

  logic [63:0] got_data[$];
  logic        got_last[$];
  logic [63:0] exp_data[$];
  logic        exp_last[$];
  int          n_last_seen = 0;

  // Stream monitor at the falling edge: records words about to transfer and checks
  // that a stalled word is held unchanged.
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data;
  logic        stall_last;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, stall_data);
        check_eq("stall_last", out_last, stall_last);
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last) n_last_seen++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_msg(input logic [15:0] id, input logic [1:0] sev, input logic [1:0] na,
                            input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] ts);
    logic [1:0] nc;
    nc = (na > 2'd2) ? 2'd2 : na;
    exp_data.push_back({sev, nc, 28'd0, 16'd0, id});
    exp_last.push_back(1'b0);
    exp_data.push_back(ts);
    exp_last.push_back(nc == 2'd0);
    if (nc >= 2'd1) begin
      exp_data.push_back(a0);
      exp_last.push_back(nc == 2'd1);
    end
    if (nc == 2'd2) begin
      exp_data.push_back(a1);
      exp_last.push_back(1'b1);
    end
  endtask

  task automatic send(input logic [15:0] id, input logic [1:0] sev, input logic [1:0] na,
                      input logic [63:0] a0, input logic [63:0] a1);
    int guard;
    guard     = 0;
    msg_valid = 1'b1;
    msg_id    = id;
    msg_sev   = sev;
    msg_nargs = na;
    msg_args  = {a1, a0};
    while (!msg_ready && guard < 200) begin
      tick();
      guard++;
    end
    check_eq("send_ready", msg_ready, 1);
    expect_msg(id, sev, na, a0, a1, tb_cyc);
    tick();
    msg_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input string tag);
    int guard;
    guard = 0;
    while (got_data.size() < n && guard < 500) begin
      tick();
      guard++;
    end
    check_eq({tag, "_words"}, got_data.size(), n);
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_len"}, got_data.size(), exp_data.size());
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), got_data[i], exp_data[i]);
      check_eq($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
    end
    got_data.delete();
    got_last.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  initial begin
    int  guard;
    int  base;
    bit  early;
    bit  hit;

    rst_n     = 1'b0;
    msg_valid = 1'b0;
    msg_id    = '0;
    msg_sev   = '0;
    msg_nargs = '0;
    msg_args  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_msg_ready", msg_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_cycle_count", cycle_count, 0);
    check_eq("rst_error_seen", error_seen, 0);
    check_eq("rst_msg_count", msg_count, 0);
    check_eq("rst_drop_count", drop_count, 0);

    // First-cycle INFO message, one argument, timestamp 0.
    msg_valid = 1'b1;
    msg_id    = 16'd1;
    msg_sev   = 2'd0;
    msg_nargs = 2'd1;
    msg_args  = {64'd0, 64'd1};
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    msg_valid = 1'b0;
    check_eq("t1_no_early_valid", out_valid, 0);
    check_eq("t1_cycle_count", cycle_count, 1);
    tick();
    check_eq("t1_hdr_valid", out_valid, 1);
    check_eq("t1_hdr_data", out_data, 64'h1000000000000001);
    exp_data.push_back(64'h1000000000000001); exp_last.push_back(1'b0);
    exp_data.push_back(64'h0);                exp_last.push_back(1'b0);
    exp_data.push_back(64'h1);                exp_last.push_back(1'b1);

    // ERROR message with no arguments accepted at cycle 5.
    guard = 0;
    while (tb_cyc != 64'd5 && guard < 20) begin
      tick();
      guard++;
    end
    msg_valid = 1'b1;
    msg_id    = 16'd19;
    msg_sev   = 2'd2;
    msg_nargs = 2'd0;
    tick();
    msg_valid = 1'b0;
    check_eq("t2_error_seen", error_seen, 1);
    exp_data.push_back(64'h8000000000000013); exp_last.push_back(1'b0);
    exp_data.push_back(64'd5);                exp_last.push_back(1'b1);
    wait_words(5, "t12");
    compare_stream("t12");
    check_eq("t2_msg_count", msg_count, 2);

    // nargs=3 is clamped to two argument words.
    send(16'h002A, 2'd1, 2'd3, 64'hA0, 64'hB1);
    wait_words(4, "t3");
    repeat (3) tick();
    check_eq("t3_exact_len", got_data.size(), 4);
    check_eq("t3_hdr", got_data[0], 64'h600000000000002A);
    compare_stream("t3");

    // Fill all DEPTH slots while the host is stalled.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(16'h0100 + 16'(i), 2'(i % 2), 2'(i % 4),
           64'hA5A5_0000_0000_0000 | 64'(i), 64'h5A5A_0000_0000_0000 | 64'(i));
    end
    check_eq("fill_msg_count", msg_count, 19);
`ifdef DISPBUF_DROP_EN
    check_eq("drop_ready_high", msg_ready, 1);
    msg_valid = 1'b1;
    msg_id    = 16'hDEAD;
    repeat (4) tick();
    msg_valid = 1'b0;
    check_eq("drop_count", drop_count, 4);
    check_eq("drop_msg_count", msg_count, 19);
`else
    check_eq("full_ready_low", msg_ready, 0);
    msg_valid = 1'b1;
    msg_id    = 16'hDEAD;
    tick();
    msg_valid = 1'b0;
    check_eq("full_no_accept", msg_count, 19);
    check_eq("nodrop_count", drop_count, 0);
`endif

    // Drain with stalls; ready must return right after the first out_last transfers.
    base  = n_last_seen;
    early = 1'b0;
    hit   = 1'b0;
    for (int g = 0; g < 200; g++) begin
      out_ready = (g % 3 != 2);
      tick();
      if (n_last_seen > base) begin
        hit = 1'b1;
        break;
      end
      if (msg_ready) early = 1'b1;
    end
    check_eq("fill_first_last_seen", hit, 1);
    check_eq("fill_ready_held_low", early, 0);
    check_eq("fill_ready_after_last", msg_ready, 1);
    guard = 0;
    while (got_data.size() < exp_data.size() && guard < 500) begin
      out_ready = (guard % 4 != 1);
      tick();
      guard++;
    end
    out_ready = 1'b1;
    repeat (3) tick();
    compare_stream("fill");

    // Back-to-back records drain one word per cycle.
    out_ready = 1'b0;
    send(16'h0200, 2'd0, 2'd1, 64'h11, 64'h0);
    send(16'h0201, 2'd1, 2'd0, 64'h0,  64'h0);
    send(16'h0202, 2'd0, 2'd2, 64'h33, 64'h44);
    repeat (2) tick();
    out_ready = 1'b1;
    guard = 0;
    while (got_data.size() < 9 && guard < 50) begin
      tick();
      guard++;
    end
    check_eq("b2b_cycles", guard, 9);
    compare_stream("b2b");
    check_eq("b2b_msg_count", msg_count, 22);
    check_eq("error_still_set", error_seen, 1);

    // Reset in the middle of a FATAL record.
    send(16'h0077, 2'd3, 2'd2, 64'h1234, 64'h5678);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_last", out_last, 0);
    check_eq("mid_rst_out_data", out_data, 0);
    check_eq("mid_rst_cycle_count", cycle_count, 0);
    check_eq("mid_rst_msg_count", msg_count, 0);
    check_eq("mid_rst_error_seen", error_seen, 0);
    check_eq("mid_rst_msg_ready", msg_ready, 1);
    check_eq("mid_rst_drop_count", drop_count, 0);
    got_data.delete();
    got_last.delete();
    exp_data.delete();
    exp_last.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_empty", out_valid, 0);
    send(16'h0055, 2'd0, 2'd1, 64'hCAFE, 64'h0);
    wait_words(3, "post_rst");
    repeat (3) tick();
    compare_stream("post_rst");
    check_eq("post_rst_msg_count", msg_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
